// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the MIPS stage registers.
// Provides default widths, the NOP encoding, the default PC increment and
// the packed entry type used between IF and ID at default widths.
package pipe_pkg;

  localparam int INSTR_W_DEF = 32;
  localparam int ADDR_W_DEF  = 32;
  localparam int PC_INC_DEF  = 4;

  // MIPS sll $0,$0,0 encodes as all zeros
  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR_DEF = '0;

  typedef struct packed {
    logic [INSTR_W_DEF-1:0] instr;
    logic [ADDR_W_DEF-1:0]  pc;
  } if_id_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready pipeline buffer, reusable for any stage register.
// SKID=1: main + skid entry, in_ready comes straight from a flop.
// SKID=0: single entry, in_ready depends combinationally on out_ready.
// Ports:
//   clock, reset       rising-edge clock, async active-high reset
//   flush              synchronous kill of all held entries
//   in_valid/in_ready  upstream handshake, in_data payload
//   out_valid/out_ready downstream handshake, out_data payload
module pipe_skid_buf #(
  parameter int W    = 64,
  parameter bit SKID = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         r_main_v;
  logic [W-1:0] r_main_d;
  logic         w_in_fire;
  logic         w_out_fire;

  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_main_v && out_ready;
  assign out_valid  = r_main_v;
  assign out_data   = r_main_d;

  generate
    if (SKID) begin : g_skid
      logic         r_skid_v;
      logic [W-1:0] r_skid_d;

      assign in_ready = !r_skid_v;

      // Data registers are left alone on flush; only the valid bits drop.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_main_v <= 1'b0;
          r_main_d <= '0;
          r_skid_v <= 1'b0;
          r_skid_d <= '0;
        end else if (flush) begin
          r_main_v <= 1'b0;
          r_skid_v <= 1'b0;
        end else if (!r_main_v || w_out_fire) begin
          // Skid drains first; in_ready is low while it is full.
          if (r_skid_v) begin
            r_main_d <= r_skid_d;
            r_main_v <= 1'b1;
            r_skid_v <= 1'b0;
          end else if (w_in_fire) begin
            r_main_d <= in_data;
            r_main_v <= 1'b1;
          end else begin
            r_main_v <= 1'b0;
          end
        end else if (w_in_fire) begin
          r_skid_d <= in_data;
          r_skid_v <= 1'b1;
        end
      end
    end else begin : g_single
      assign in_ready = !r_main_v || out_ready;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_main_v <= 1'b0;
          r_main_d <= '0;
        end else if (flush) begin
          r_main_v <= 1'b0;
        end else if (w_in_fire) begin
          r_main_d <= in_data;
          r_main_v <= 1'b1;
        end else if (!r_main_v || w_out_fire) begin
          r_main_v <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline stage between instruction fetch and decode.
// Captures instruction and PC+PC_INC, substitutes NOP_INSTR when empty,
// supports flush and counts decode stall cycles (saturating).
// Ports:
//   clock, reset           rising-edge clock, async active-high reset
//   in_valid/in_ready      fetch handshake; in_instr, in_pc payload
//   flush                  branch/jump taken: drop everything held
//   out_valid/out_ready    decode handshake; out_instr, out_pc payload
//   stall_count            cycles with out_valid && !out_ready
module if_id_stage
  import pipe_pkg::*;
#(
  parameter int                 INSTR_W   = INSTR_W_DEF,
  parameter int                 ADDR_W    = ADDR_W_DEF,
  parameter int                 PC_INC    = PC_INC_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF),
  parameter bit                 SKID      = 1'b1,
  parameter int                 CNT_W     = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [ADDR_W-1:0]  in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [CNT_W-1:0]   stall_count
);

  localparam int W = INSTR_W + ADDR_W;

  logic [ADDR_W-1:0] w_pc_inc;
  logic [W-1:0]      w_in_data;
  logic [W-1:0]      w_out_data;
  logic [CNT_W-1:0]  r_stall_cnt;

  // Increment at capture so the stored value never follows a live in_pc.
  assign w_pc_inc  = in_pc + ADDR_W'(PC_INC);
  assign w_in_data = {in_instr, w_pc_inc};

  pipe_skid_buf #(
    .W    (W),
    .SKID (SKID)
  ) u_buf (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_out_data)
  );

  assign out_instr = out_valid ? w_out_data[W-1:ADDR_W] : NOP_INSTR;
  assign out_pc    = w_out_data[ADDR_W-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_ready && !flush && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // u_a: defaults (SKID=1, 32/32, PC_INC=4)
  logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
  logic [31:0] a_in_instr, a_in_pc, a_out_instr, a_out_pc;
  logic [15:0] a_stall;
  // u_b: ADDR_W=16, PC_INC=8
  logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
  logic [31:0] b_in_instr, b_out_instr;
  logic [15:0] b_in_pc, b_out_pc, b_stall;
  // u_c: SKID=0, CNT_W=4
  logic        c_in_valid, c_in_ready, c_flush, c_out_valid, c_out_ready;
  logic [31:0] c_in_instr, c_in_pc, c_out_instr, c_out_pc;
  logic [3:0]  c_stall;

  if_id_stage u_a (
    .clock(clock), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_instr(a_in_instr), .in_pc(a_in_pc), .flush(a_flush), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_instr(a_out_instr), .out_pc(a_out_pc),
    .stall_count(a_stall));

  if_id_stage #(.ADDR_W(16), .PC_INC(8)) u_b (
    .clock(clock), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_instr(b_in_instr), .in_pc(b_in_pc), .flush(b_flush), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_instr(b_out_instr), .out_pc(b_out_pc),
    .stall_count(b_stall));

  if_id_stage #(.SKID(1'b0), .CNT_W(4)) u_c (
    .clock(clock), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_instr(c_in_instr), .in_pc(c_in_pc), .flush(c_flush), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_instr(c_out_instr), .out_pc(c_out_pc),
    .stall_count(c_stall));

  int n_vec = 0;
  int n_err = 0;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    a_in_valid = v;
    a_in_instr = instr;
    a_in_pc    = pc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    drive_a(1'b0, 32'h0, 32'h0);
    a_flush = 0; a_out_ready = 1;
    b_in_valid = 0; b_in_instr = 0; b_in_pc = 0; b_flush = 0; b_out_ready = 1;
    c_in_valid = 0; c_in_instr = 0; c_in_pc = 0; c_flush = 0; c_out_ready = 1;
    step();
    step();
    check_vec("rst_out_valid", a_out_valid, 0);
    check_vec("rst_out_instr", a_out_instr, 0);
    check_vec("rst_out_pc", a_out_pc, 0);
    check_vec("rst_stall", a_stall, 0);
    check_vec("rst_in_ready", a_in_ready, 1);
    reset = 0;

    // streaming
    drive_a(1'b1, 32'h20080005, 32'h00400000);
    step();
    check_vec("str0_valid", a_out_valid, 1);
    check_vec("str0_instr", a_out_instr, 32'h20080005);
    check_vec("str0_pc", a_out_pc, 32'h00400004);
    check_vec("str0_in_ready", a_in_ready, 1);
    drive_a(1'b1, 32'h21090001, 32'h00400004);
    step();
    check_vec("str1_instr", a_out_instr, 32'h21090001);
    check_vec("str1_pc", a_out_pc, 32'h00400008);
    check_vec("str1_in_ready", a_in_ready, 1);
    drive_a(1'b1, 32'h08000000, 32'hFFFFFFFC);
    step();
    check_vec("wrap32_pc", a_out_pc, 32'h00000000);
    check_vec("wrap32_instr", a_out_instr, 32'h08000000);
    drive_a(1'b0, 32'h0, 32'h0);
    step();
    check_vec("str_empty_valid", a_out_valid, 0);
    check_vec("str_empty_nop", a_out_instr, 0);
    check_vec("str_stall", a_stall, 0);

    // stall with skid: A, B, C
    a_out_ready = 0;
    drive_a(1'b1, 32'h8C020000, 32'h00000100);
    step();
    check_vec("stl1_instr", a_out_instr, 32'h8C020000);
    check_vec("stl1_in_ready", a_in_ready, 1);
    drive_a(1'b1, 32'h8C030004, 32'h00000104);
    step();
    check_vec("stl2_instr", a_out_instr, 32'h8C020000);
    check_vec("stl2_in_ready", a_in_ready, 0);
    drive_a(1'b1, 32'h00431020, 32'h00000108);
    step();
    check_vec("stl3_instr", a_out_instr, 32'h8C020000);
    check_vec("stl3_in_ready", a_in_ready, 0);
    check_vec("stl3_stall", a_stall, 2);
    step();
    check_vec("stl4_stall", a_stall, 3);
    check_vec("stl4_pc", a_out_pc, 32'h00000104);
    a_out_ready = 1;
    step();
    check_vec("rel_b_instr", a_out_instr, 32'h8C030004);
    check_vec("rel_b_pc", a_out_pc, 32'h00000108);
    check_vec("rel_b_in_ready", a_in_ready, 1);
    step();
    check_vec("rel_c_instr", a_out_instr, 32'h00431020);
    check_vec("rel_c_pc", a_out_pc, 32'h0000010C);
    drive_a(1'b0, 32'h0, 32'h0);
    step();
    check_vec("rel_empty", a_out_valid, 0);
    check_vec("rel_stall", a_stall, 3);

    // flush with main=A, skid=B, C offered
    a_out_ready = 0;
    drive_a(1'b1, 32'h11111111, 32'h00000200);
    step();
    drive_a(1'b1, 32'h22222222, 32'h00000204);
    step();
    check_vec("fl_pre_in_ready", a_in_ready, 0);
    drive_a(1'b1, 32'h33333333, 32'h00000208);
    a_flush = 1;
    step();
    a_flush = 0;
    check_vec("fl_valid", a_out_valid, 0);
    check_vec("fl_instr", a_out_instr, 0);
    check_vec("fl_in_ready", a_in_ready, 1);
    check_vec("fl_stall", a_stall, 4);
    a_out_ready = 1;
    drive_a(1'b1, 32'h44444444, 32'h00000300);
    step();
    check_vec("fl_d_instr", a_out_instr, 32'h44444444);
    check_vec("fl_d_pc", a_out_pc, 32'h00000304);
    drive_a(1'b0, 32'h0, 32'h0);
    step();
    check_vec("fl_d_drained", a_out_valid, 0);

    // flush discards an accepted input while skid empty
    a_out_ready = 0;
    drive_a(1'b1, 32'h11111111, 32'h00000400);
    step();
    drive_a(1'b1, 32'h33333333, 32'h00000404);
    a_flush = 1;
    step();
    a_flush = 0;
    drive_a(1'b0, 32'h0, 32'h0);
    check_vec("fl2_valid", a_out_valid, 0);
    step();
    check_vec("fl2_no_leak", a_out_valid, 0);
    check_vec("fl2_stall", a_stall, 4);
    a_out_ready = 1;

    // 16-bit PC wrap with PC_INC=8
    b_in_valid = 1; b_in_instr = 32'h12345678; b_in_pc = 16'hFFFC;
    step();
    b_in_valid = 0;
    check_vec("wrap16_pc", b_out_pc, 16'h0004);
    check_vec("wrap16_instr", b_out_instr, 32'h12345678);

    // SKID=0 stall and counter saturation
    c_out_ready = 0;
    c_in_valid = 1; c_in_instr = 32'hAAAA0001; c_in_pc = 32'h00001000;
    #1;
    check_vec("s0_ready_empty", c_in_ready, 1);
    step();
    check_vec("s0_ready_stall", c_in_ready, 0);
    check_vec("s0_a_instr", c_out_instr, 32'hAAAA0001);
    c_in_instr = 32'hBBBB0002; c_in_pc = 32'h00001004;
    step();
    check_vec("s0_stall1", c_stall, 1);
    for (int i = 0; i < 19; i++) step();
    check_vec("s0_sat", c_stall, 15);
    check_vec("s0_a_held", c_out_instr, 32'hAAAA0001);
    check_vec("s0_a_pc", c_out_pc, 32'h00001004);
    c_out_ready = 1;
    #1;
    check_vec("s0_ready_comb", c_in_ready, 1);
    step();
    check_vec("s0_b_instr", c_out_instr, 32'hBBBB0002);
    check_vec("s0_b_pc", c_out_pc, 32'h00001008);
    check_vec("s0_sat_hold", c_stall, 15);
    c_in_valid = 0;
    step();
    check_vec("s0_empty", c_out_valid, 0);

    // async reset mid-operation
    a_out_ready = 0;
    drive_a(1'b1, 32'h55555555, 32'h00000500);
    step();
    drive_a(1'b0, 32'h0, 32'h0);
    step();
    check_vec("mr_pre_valid", a_out_valid, 1);
    check_vec("mr_pre_stall", a_stall, 5);
    #2;
    reset = 1;
    #1;
    check_vec("mr_valid", a_out_valid, 0);
    check_vec("mr_instr", a_out_instr, 0);
    check_vec("mr_pc", a_out_pc, 0);
    check_vec("mr_stall", a_stall, 0);
    check_vec("mr_in_ready", a_in_ready, 1);
    check_vec("mr_c_stall", c_stall, 0);
    #2;
    reset = 0;
    step();
    check_vec("mr_after_valid", a_out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
